// File: rtl/stack_rpn_pkg.sv
// Shared constants for the RPN stack controller: opcodes, FSM encodings, default sizes.
package stack_rpn_pkg;

  localparam int unsigned WIDTH_DEF = 16;
  localparam int unsigned DEPTH_DEF = 6;
  localparam int unsigned DEPTH_W   = 3;
  localparam int unsigned OP_W      = 3;
  localparam int unsigned ST_W      = 3;

  localparam logic [OP_W-1:0] OP_NOP  = 3'd0;
  localparam logic [OP_W-1:0] OP_PUSH = 3'd1;
  localparam logic [OP_W-1:0] OP_DROP = 3'd2;
  localparam logic [OP_W-1:0] OP_DUP  = 3'd3;
  localparam logic [OP_W-1:0] OP_ADD  = 3'd4;
  localparam logic [OP_W-1:0] OP_SUB  = 3'd5;
  localparam logic [OP_W-1:0] OP_MUL  = 3'd6;
  localparam logic [OP_W-1:0] OP_RSV  = 3'd7;

  localparam logic [ST_W-1:0] IDLE = 3'd0;
  localparam logic [ST_W-1:0] PUSH = 3'd1;
  localparam logic [ST_W-1:0] POP1 = 3'd2;
  localparam logic [ST_W-1:0] CALC = 3'd3;
  localparam logic [ST_W-1:0] POP2 = 3'd4;
  localparam logic [ST_W-1:0] WB   = 3'd5;

endpackage

// File: rtl/stack_rpn_alu.sv
// Combinational binary ALU for the RPN controller (qnext OP qtop, modulo 2^WIDTH).
// The multiplier exists only when STACK_RPN_MUL_EN is defined.
module stack_rpn_alu
  import stack_rpn_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] qnext,
  input  logic [WIDTH-1:0] qtop,
  output logic [WIDTH-1:0] result_c
);

  always_comb begin
    result_c = '0;
    case (op)
      OP_ADD:  result_c = qnext + qtop;
      OP_SUB:  result_c = qnext - qtop;
`ifdef STACK_RPN_MUL_EN
      OP_MUL:  result_c = qnext * qtop;
`else
      OP_MUL:  result_c = '0;
`endif
      default: result_c = '0;
    endcase
  end

endmodule

// File: rtl/stack_rpn_ctrl.sv
// RPN command master for the 6-entry hardware stack: decodes commands, sequences
// push/pop/load strobes, tracks depth and flags misuse. MUL needs STACK_RPN_MUL_EN.
module stack_rpn_ctrl
  import stack_rpn_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [OP_W-1:0]    cmd_op,
  input  logic [WIDTH-1:0]   cmd_data,
  output logic               st_load,
  output logic               st_push,
  output logic               st_pop,
  output logic [WIDTH-1:0]   st_d,
  input  logic [WIDTH-1:0]   st_qtop,
  input  logic [WIDTH-1:0]   st_qnext,
  output logic               res_valid,
  output logic [WIDTH-1:0]   res_data,
  output logic [DEPTH_W-1:0] depth,
  output logic               err_ovf,
  output logic               err_unf,
  output logic               err_ill
);

  logic [ST_W-1:0]    state, state_n;
  logic [OP_W-1:0]    op_q, op_n;
  logic [WIDTH-1:0]   alu_r, alu_r_n, alu_c;
  logic [WIDTH-1:0]   st_d_n, res_data_n;
  logic [DEPTH_W-1:0] depth_n;
  logic               cmd_ready_n, st_load_n, st_push_n, st_pop_n, res_valid_n;
  logic               ovf_n, unf_n, ill_n;
  logic               full, empty, lt2;

  assign full  = (depth == DEPTH_W'(DEPTH));
  assign empty = (depth == '0);
  assign lt2   = (depth < DEPTH_W'(2));

  stack_rpn_alu #(.WIDTH(WIDTH)) u_alu (
    .op       (op_q),
    .qnext    (st_qnext),
    .qtop     (st_qtop),
    .result_c (alu_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      op_q      <= OP_NOP;
      alu_r     <= '0;
      cmd_ready <= 1'b1;
      st_load   <= 1'b0;
      st_push   <= 1'b0;
      st_pop    <= 1'b0;
      st_d      <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      depth     <= '0;
      err_ovf   <= 1'b0;
      err_unf   <= 1'b0;
      err_ill   <= 1'b0;
    end else begin
      state     <= state_n;
      op_q      <= op_n;
      alu_r     <= alu_r_n;
      cmd_ready <= cmd_ready_n;
      st_load   <= st_load_n;
      st_push   <= st_push_n;
      st_pop    <= st_pop_n;
      st_d      <= st_d_n;
      res_valid <= res_valid_n;
      res_data  <= res_data_n;
      depth     <= depth_n;
      err_ovf   <= ovf_n;
      err_unf   <= unf_n;
      err_ill   <= ill_n;
    end
  end

  // Strobes are computed one state ahead so each is registered and high for exactly the target state.
  always_comb begin
    state_n     = state;
    op_n        = op_q;
    alu_r_n     = alu_r;
    st_load_n   = 1'b0;
    st_push_n   = 1'b0;
    st_pop_n    = 1'b0;
    res_valid_n = 1'b0;
    st_d_n      = st_d;
    res_data_n  = res_data;
    depth_n     = depth;
    ovf_n       = err_ovf;
    unf_n       = err_unf;
    ill_n       = err_ill;

    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          op_n = cmd_op;
          case (cmd_op)
            OP_NOP: ;
            OP_PUSH: begin
              if (full) ovf_n = 1'b1;
              else begin
                state_n   = PUSH;
                st_push_n = 1'b1;
                st_d_n    = cmd_data;
              end
            end
            OP_DUP: begin
              if (empty) unf_n = 1'b1;
              else if (full) ovf_n = 1'b1;
              else begin
                state_n   = PUSH;
                st_push_n = 1'b1;
                st_d_n    = st_qtop;
              end
            end
            OP_DROP: begin
              if (empty) unf_n = 1'b1;
              else begin
                state_n  = POP1;
                st_pop_n = 1'b1;
              end
            end
            OP_ADD, OP_SUB: begin
              if (lt2) unf_n = 1'b1;
              else state_n = CALC;
            end
`ifdef STACK_RPN_MUL_EN
            OP_MUL: begin
              if (lt2) unf_n = 1'b1;
              else state_n = CALC;
            end
`else
            OP_MUL: ill_n = 1'b1;
`endif
            default: ill_n = 1'b1;
          endcase
        end
      end
      PUSH: begin
        depth_n = depth + DEPTH_W'(1);
        state_n = IDLE;
      end
      POP1: begin
        depth_n = depth - DEPTH_W'(1);
        state_n = IDLE;
      end
      CALC: begin
        alu_r_n  = alu_c;
        state_n  = POP2;
        st_pop_n = 1'b1;
      end
      POP2: begin
        depth_n     = depth - DEPTH_W'(1);
        state_n     = WB;
        st_load_n   = 1'b1;
        st_d_n      = alu_r;
        res_valid_n = 1'b1;
        res_data_n  = alu_r;
      end
      WB:      state_n = IDLE;
      default: state_n = IDLE;
    endcase

    cmd_ready_n = (state_n == IDLE);
  end

endmodule

// File: tb/tb_stack_rpn_ctrl.sv
// Directed self-checking bench: stack_rpn_ctrl driving a behavioural 6-entry stack.
module tb_stack_rpn_ctrl;
  import stack_rpn_pkg::*;

  logic        clk, rst;
  logic        cmd_valid, cmd_ready;
  logic [2:0]  cmd_op;
  logic [15:0] cmd_data;
  logic        st_load, st_push, st_pop;
  logic [15:0] st_d, st_qtop, st_qnext;
  logic        res_valid;
  logic [15:0] res_data;
  logic [2:0]  depth;
  logic        err_ovf, err_unf, err_ill;

  int checks = 0;
  int errors = 0;
  int n_strobe = 0;
  int n_res = 0;
  int n_excl = 0;
  int snap_s, snap_r;

  logic [15:0] stk [0:5];

  stack_rpn_ctrl dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .st_load(st_load), .st_push(st_push), .st_pop(st_pop), .st_d(st_d),
    .st_qtop(st_qtop), .st_qnext(st_qnext),
    .res_valid(res_valid), .res_data(res_data), .depth(depth),
    .err_ovf(err_ovf), .err_unf(err_unf), .err_ill(err_ill)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural stack6: push shifts down, pop shifts up, load overwrites top.
  always_ff @(posedge clk) begin
    if (st_push) begin
      for (int i = 5; i > 0; i--) stk[i] <= stk[i-1];
      stk[0] <= st_d;
    end else if (st_pop) begin
      for (int i = 0; i < 5; i++) stk[i] <= stk[i+1];
    end else if (st_load) begin
      stk[0] <= st_d;
    end
  end
  assign st_qtop  = stk[0];
  assign st_qnext = stk[1];

  always @(posedge clk) begin
    if ((32'(st_push) + 32'(st_pop) + 32'(st_load)) > 1) n_excl++;
    if (st_push || st_pop || st_load) n_strobe++;
    if (res_valid) n_res++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 32'(cmd_ready), 32'd1);
  endtask

  // Presents one command for one accept edge; returns at the negedge after acceptance.
  task automatic send(input logic [2:0] op, input logic [15:0] d);
    @(negedge clk);
    wait_idle();
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_data = 16'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_depth", 32'(depth), 32'd0);
    chk("rst_strobes", {29'd0, st_load, st_push, st_pop}, 32'd0);
    chk("rst_std", 32'(st_d), 32'd0);
    chk("rst_res", {15'd0, res_valid, res_data}, 32'd0);
    chk("rst_flags", {29'd0, err_ovf, err_unf, err_ill}, 32'd0);

    // 1: PUSH 1111, PUSH 2222, ADD with cycle-exact latency
    send(OP_PUSH, 16'h1111);
    chk("t1_push_strobe", {30'd0, st_push, cmd_ready}, 32'd2);
    chk("t1_push_d", 32'(st_d), 32'h1111);
    @(negedge clk);
    chk("t1_push_done", {29'd0, cmd_ready, depth}, {29'd0, 1'b1, 3'd1});
    chk("t1_qtop1", 32'(st_qtop), 32'h1111);
    send(OP_PUSH, 16'h2222);
    wait_idle();
    send(OP_ADD, 16'h0);
    chk("t1_calc", {29'd0, cmd_ready, st_pop, st_load}, 32'd0);
    @(negedge clk);
    chk("t1_pop2", {29'd0, st_pop, st_load, res_valid}, 32'd4);
    @(negedge clk);
    chk("t1_wb", {29'd0, st_pop, st_load, res_valid}, 32'd3);
    chk("t1_res", 32'(res_data), 32'h3333);
    chk("t1_ready_wb", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    chk("t1_ready_back", 32'(cmd_ready), 32'd1);
    chk("t1_qtop", 32'(st_qtop), 32'h3333);
    chk("t1_depth", 32'(depth), 32'd1);
    chk("t1_res_hold", {15'd0, res_valid, res_data}, 32'h3333);

    // 2: SUB wraps, then DUP
    do_reset();
    send(OP_PUSH, 16'h0005);
    send(OP_PUSH, 16'h0007);
    snap_r = n_res;
    send(OP_SUB, 16'h0);
    wait_idle();
    chk("t2_res", 32'(res_data), 32'hFFFE);
    chk("t2_resv_cnt", 32'(n_res - snap_r), 32'd1);
    chk("t2_depth_sub", 32'(depth), 32'd1);
    send(OP_DUP, 16'h0);
    wait_idle();
    chk("t2_depth_dup", 32'(depth), 32'd2);
    chk("t2_qtop", 32'(st_qtop), 32'hFFFE);
    chk("t2_qnext", 32'(st_qnext), 32'hFFFE);

    // 3: overflow on the seventh push
    do_reset();
    for (int i = 1; i <= 6; i++) send(OP_PUSH, 16'(i * 32'h1111));
    wait_idle();
    chk("t3_depth6", 32'(depth), 32'd6);
    chk("t3_no_ovf", 32'(err_ovf), 32'd0);
    snap_s = n_strobe;
    send(OP_PUSH, 16'h7777);
    wait_idle();
    chk("t3_ovf", 32'(err_ovf), 32'd1);
    chk("t3_depth", 32'(depth), 32'd6);
    chk("t3_qtop", 32'(st_qtop), 32'h6666);
    chk("t3_no_strobe", 32'(n_strobe - snap_s), 32'd0);

    // 4: underflow on DROP from empty, then ADD with one entry
    do_reset();
    snap_s = n_strobe;
    send(OP_DROP, 16'h0);
    @(negedge clk);
    chk("t4_drop_unf", 32'(err_unf), 32'd1);
    chk("t4_drop_depth", 32'(depth), 32'd0);
    chk("t4_drop_nostrobe", 32'(n_strobe - snap_s), 32'd0);
    do_reset();
    send(OP_PUSH, 16'h00AA);
    wait_idle();
    snap_s = n_strobe;
    send(OP_ADD, 16'h0);
    chk("t4_add_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    chk("t4_add_unf", 32'(err_unf), 32'd1);
    chk("t4_add_depth", 32'(depth), 32'd1);
    chk("t4_add_nostrobe", 32'(n_strobe - snap_s), 32'd0);
    chk("t4_add_qtop", 32'(st_qtop), 32'h00AA);

    // 5: reserved opcode and MUL
    do_reset();
    snap_s = n_strobe;
    send(OP_RSV, 16'h0);
    @(negedge clk);
    chk("t5_ill", 32'(err_ill), 32'd1);
    chk("t5_ill_nostrobe", 32'(n_strobe - snap_s), 32'd0);
    do_reset();
    send(OP_PUSH, 16'h0100);
    send(OP_PUSH, 16'h0100);
    snap_r = n_res;
    send(OP_MUL, 16'h0);
    repeat (4) @(negedge clk);
    wait_idle();
`ifdef STACK_RPN_MUL_EN
    chk("t5_mul_ill", 32'(err_ill), 32'd0);
    chk("t5_mul_res", 32'(res_data), 32'h0000);
    chk("t5_mul_qtop", 32'(st_qtop), 32'h0000);
    chk("t5_mul_depth", 32'(depth), 32'd1);
    chk("t5_mul_resv", 32'(n_res - snap_r), 32'd1);
`else
    chk("t5_mul_ill", 32'(err_ill), 32'd1);
    chk("t5_mul_depth", 32'(depth), 32'd2);
    chk("t5_mul_resv", 32'(n_res - snap_r), 32'd0);
`endif

    // 6: reset asserted during POP2 of an ADD
    do_reset();
    send(OP_RSV, 16'h0);
    send(OP_PUSH, 16'h0001);
    send(OP_PUSH, 16'h0002);
    send(OP_ADD, 16'h0);
    @(negedge clk);
    chk("t6_in_pop2", 32'(st_pop), 32'd1);
    chk("t6_ill_set", 32'(err_ill), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_strobes", {29'd0, st_load, st_push, st_pop}, 32'd0);
    chk("t6_resv", 32'(res_valid), 32'd0);
    chk("t6_depth", 32'(depth), 32'd0);
    chk("t6_ready", 32'(cmd_ready), 32'd1);
    chk("t6_flags", {29'd0, err_ovf, err_unf, err_ill}, 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("t6_no_wb", 32'(res_valid), 32'd0);

    chk("strobe_excl", 32'(n_excl), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
